// File: rtl/uart_host_port.sv
// uart_host_port: host-side initiator for the UART register port.
// Bridges TX/RX byte streams (4-deep FIFOs) onto config/status/data strobes.
module uart_host_port (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cfg,
    input  logic       cfg_load,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [2:0] err,
    input  logic       err_clr,
    input  logic       uart_int,
    input  logic [7:0] udo,
    output logic [7:0] writes,
    output logic [7:0] reads,
    output logic [7:0] udi
);

    typedef enum logic [2:0] {CFG, IDLE, STAT, RDATA, WDATA} state_t;

    state_t     state, nxt;
    logic       booted, int_pend, rx_hold;
    logic [7:0] tx_mem [4];
    logic [7:0] rx_mem [4];
    logic [1:0] tx_rd, tx_wr, rx_rd, rx_wr;
    logic [2:0] tx_cnt, rx_cnt;
    logic       tx_push, tx_pop, rx_push, rx_pop;
    logic       tx_empty, rx_full;

    assign tx_empty = (tx_cnt == 3'd0);
    assign rx_full  = (rx_cnt == 3'd4);
    assign tx_ready = (tx_cnt != 3'd4);
    assign rx_valid = (rx_cnt != 3'd0);
    assign rx_data  = rx_mem[rx_rd];
    assign tx_push  = tx_valid && tx_ready;
    assign tx_pop   = (state == WDATA);
    assign rx_push  = (state == RDATA);
    assign rx_pop   = rx_valid && rx_ready;

    // Raw uart_int and same-cycle TX push are looked at so IDLE polls next cycle.
    always_comb begin
        nxt = state;
        case (state)
            CFG:   nxt = booted ? IDLE : CFG;
            IDLE: begin
                if (cfg_load)
                    nxt = CFG;
                else if (int_pend || uart_int || !tx_empty || tx_push
                         || (rx_hold && !rx_full))
                    nxt = STAT;
            end
            STAT: begin
                if (udo[0] && !rx_full)
                    nxt = RDATA;
                else if (udo[1] && !tx_empty)
                    nxt = WDATA;
                else
                    nxt = IDLE;
            end
            RDATA: nxt = IDLE;
            WDATA: nxt = IDLE;
            default: nxt = CFG;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CFG;
            booted   <= 1'b0;
            writes   <= 8'h00;
            reads    <= 8'h00;
            udi      <= 8'h00;
            int_pend <= 1'b0;
            rx_hold  <= 1'b0;
            err      <= 3'b000;
            tx_rd    <= 2'd0;
            tx_wr    <= 2'd0;
            tx_cnt   <= 3'd0;
            rx_rd    <= 2'd0;
            rx_wr    <= 2'd0;
            rx_cnt   <= 3'd0;
        end else begin
            state  <= nxt;
            booted <= 1'b1;
            writes <= 8'h00;
            reads  <= 8'h00;
            udi    <= 8'h00;
            case (nxt)
                CFG: begin
                    writes <= 8'h40;
                    udi    <= cfg;
                end
                STAT:  reads <= 8'h02;
                RDATA: reads <= 8'h01;
                WDATA: begin
                    writes <= 8'h01;
                    udi    <= tx_mem[tx_rd];
                end
                default: ;
            endcase

            if (uart_int)
                int_pend <= 1'b1;
            else if (nxt == STAT)
                int_pend <= 1'b0;

            err <= (err_clr ? 3'b000 : err)
                 | ((state == STAT) ? udo[4:2] : 3'b000);

            if (state == STAT)
                rx_hold <= udo[0] && rx_full;
            else if (state == RDATA)
                rx_hold <= 1'b0;

            if (tx_push) tx_wr <= tx_wr + 2'd1;
            if (tx_pop)  tx_rd <= tx_rd + 2'd1;
            tx_cnt <= tx_cnt + {2'b00, tx_push} - {2'b00, tx_pop};

            if (rx_push) rx_wr <= rx_wr + 2'd1;
            if (rx_pop)  rx_rd <= rx_rd + 2'd1;
            rx_cnt <= rx_cnt + {2'b00, rx_push} - {2'b00, rx_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= tx_data;
        if (rx_push) rx_mem[rx_wr] <= udo;
    end

endmodule

// File: tb/tb_uart_host_port.sv
// Self-checking bench for uart_host_port with a behavioural UART register model.
module tb_uart_host_port;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] cfg = 8'h3C;
    logic       cfg_load = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [2:0] err;
    logic       err_clr = 1'b0;
    logic       uart_int = 1'b0;
    logic [7:0] udo;
    logic [7:0] writes, reads, udi;

    uart_host_port dut (
        .clk(clk), .rst(rst), .cfg(cfg), .cfg_load(cfg_load),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .err(err), .err_clr(err_clr), .uart_int(uart_int), .udo(udo),
        .writes(writes), .reads(reads), .udi(udi)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // UART side model: received-byte queue, TX_RDY flag, pending error bits.
    logic [7:0] rxm [0:1023];
    int         rxm_wr = 0;
    int         rxm_rd = 0;
    logic       tx_rdy_m = 1'b1;
    logic [2:0] stat_err = 3'b000;
    logic [7:0] tx_got [0:2047];
    int         tx_n = 0;
    int         stat_n = 0;
    int         rdata_n = 0;

    always_comb begin
        udo = 8'h00;
        if (reads == 8'h02)
            udo = {3'b000, stat_err, tx_rdy_m, (rxm_wr != rxm_rd)};
        else if (reads == 8'h01)
            udo = rxm[rxm_rd];
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (reads != 8'h00 || writes != 8'h00) begin
                checks++;
                if ((reads != 8'h00 && writes != 8'h00)
                    || $countones(reads) > 1 || $countones(writes) > 1) begin
                    errors++;
                    $display("FAIL strobe_excl: reads=%h writes=%h", reads, writes);
                end
            end
            if (reads == 8'h01) begin
                rxm_rd++;
                rdata_n++;
            end
            if (reads == 8'h02) stat_n++;
            if (writes == 8'h01) begin
                tx_got[tx_n] = udi;
                tx_n++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic uart_rx(input logic [7:0] b);
        rxm[rxm_wr] = b;
        rxm_wr++;
    endtask

    task automatic push_tx(input logic [7:0] d);
        int k;
        tx_data  = d;
        tx_valid = 1'b1;
        k = 0;
        while (!tx_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("push_tx_ready", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int target);
        int k;
        k = 0;
        while (tx_n < target && k < 80) begin
            @(negedge clk);
            k++;
        end
        chk("wait_tx_count", tx_n, target);
    endtask

    task automatic wait_rxv();
        int k;
        k = 0;
        while (!rx_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("wait_rx_valid", rx_valid, 1);
    endtask

    typedef struct {
        bit         is_rx;
        logic [7:0] data;
        logic [2:0] serr;
        logic [2:0] exp_err;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int n0, r0, k;
        logic [7:0] b;
        logic [7:0] exp_b;
        logic [7:0] tx_exp [$];
        logic [7:0] rx_exp [$];

        tbl[0] = '{1'b0, 8'h3C, 3'b000, 3'b000};
        tbl[1] = '{1'b1, 8'hC3, 3'b100, 3'b100};
        tbl[2] = '{1'b0, 8'h00, 3'b000, 3'b000};
        tbl[3] = '{1'b1, 8'hFF, 3'b010, 3'b010};
        tbl[4] = '{1'b0, 8'hFF, 3'b000, 3'b000};
        tbl[5] = '{1'b1, 8'h00, 3'b110, 3'b110};

        // Reset and config pulse
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_writes", writes, 0);
        chk("rst_reads", reads, 0);
        chk("rst_udi", udi, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("cfg_writes", writes, 8'h40);
        chk("cfg_udi", udi, 8'h3C);
        @(negedge clk);
        chk("cfg_end_writes", writes, 0);
        chk("cfg_end_reads", reads, 0);
        cyc(3);

        // Single transmit, latency STAT +1, WDATA +2
        tx_rdy_m = 1'b1;
        n0 = tx_n;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("tx1_stat", reads, 8'h02);
        chk("tx1_ready", tx_ready, 1);
        @(negedge clk);
        chk("tx1_writes", writes, 8'h01);
        chk("tx1_udi", udi, 8'hA5);
        @(negedge clk);
        chk("tx1_done", writes, 0);
        chk("tx1_got", tx_got[n0], 8'hA5);
        cyc(3);

        // Receive with parity error
        tx_rdy_m = 1'b0;
        uart_rx(8'h5A);
        stat_err = 3'b001;
        uart_int = 1'b1;
        @(negedge clk);
        uart_int = 1'b0;
        chk("rx1_stat", reads, 8'h02);
        @(negedge clk);
        chk("rx1_rdata", reads, 8'h01);
        @(negedge clk);
        stat_err = 3'b000;
        chk("rx1_valid", rx_valid, 1);
        chk("rx1_data", rx_data, 8'h5A);
        chk("rx1_err", err, 3'b001);
        cyc(4);
        chk("rx1_err_sticky", err, 3'b001);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        err_clr  = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("rx1_err_clr", err, 0);
        chk("rx1_empty", rx_valid, 0);
        cyc(3);

        // Table-driven transfers
        tx_rdy_m = 1'b1;
        foreach (tbl[i]) begin
            if (!tbl[i].is_rx) begin
                n0 = tx_n;
                push_tx(tbl[i].data);
                wait_tx(n0 + 1);
                chk("tbl_tx_byte", tx_got[n0], tbl[i].data);
            end else begin
                uart_rx(tbl[i].data);
                stat_err = tbl[i].serr;
                uart_int = 1'b1;
                @(negedge clk);
                uart_int = 1'b0;
                wait_rxv();
                stat_err = 3'b000;
                chk("tbl_rx_byte", rx_data, tbl[i].data);
                chk("tbl_rx_err", err, tbl[i].exp_err);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
                cyc(4);
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
                chk("tbl_err_clr", err, 0);
            end
            cyc(3);
        end

        // TX FIFO full and pointer wrap
        tx_rdy_m = 1'b0;
        n0 = tx_n;
        for (int i = 1; i <= 4; i++) push_tx(8'(i));
        chk("txf_full", tx_ready, 0);
        fork
            push_tx(8'h05);
            begin
                cyc(5);
                chk("txf_held", tx_ready, 0);
                chk("txf_none_sent", tx_n, n0);
                tx_rdy_m = 1'b1;
            end
        join
        wait_tx(n0 + 5);
        for (int i = 0; i < 5; i++)
            chk("txf_order", tx_got[n0 + i], 8'(i + 1));
        cyc(4);

        // RX backpressure
        r0 = rdata_n;
        for (int i = 0; i < 5; i++) begin
            uart_rx(8'(8'h10 + i));
            uart_int = 1'b1;
            @(negedge clk);
            uart_int = 1'b0;
            cyc(6);
        end
        chk("rxb_reads", rdata_n - r0, 4);
        chk("rxb_left", rxm_wr - rxm_rd, 1);
        chk("rxb_hold", dut.rx_hold, 1);
        chk("rxb_head", rx_data, 8'h10);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        k = 0;
        while (rdata_n - r0 < 5 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("rxb_resume", rdata_n - r0, 5);
        for (int i = 1; i <= 4; i++) begin
            wait_rxv();
            chk("rxb_order", rx_data, 8'(8'h10 + i));
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
        @(negedge clk);
        chk("rxb_empty", rx_valid, 0);
        cyc(3);

        // uart_int on STAT entry gives a second STAT
        uart_int = 1'b1;
        @(negedge clk);
        uart_int = 1'b0;
        chk("int_stat1", reads, 8'h02);
        @(negedge clk);
        chk("int_idle1", reads, 0);
        @(negedge clk);
        chk("int_stat2", reads, 8'h02);
        @(negedge clk);
        chk("int_idle2", reads, 0);
        @(negedge clk);
        chk("int_no_third", reads, 0);
        cyc(2);

        // cfg_load wins over pending TX
        n0 = tx_n;
        cfg = 8'h81;
        cfg_load = 1'b1;
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        tx_valid = 1'b0;
        chk("cl_writes", writes, 8'h40);
        chk("cl_udi", udi, 8'h81);
        @(negedge clk);
        chk("cl_idle", reads | writes, 0);
        @(negedge clk);
        chk("cl_stat", reads, 8'h02);
        @(negedge clk);
        chk("cl_wdata", writes, 8'h01);
        chk("cl_wudi", udi, 8'h77);
        cyc(3);

        // Reset during WDATA
        n0 = tx_n;
        tx_data  = 8'h99;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        chk("rw_wdata", writes, 8'h01);
        #1 rst = 1'b1;
        #1;
        chk("rw_writes", writes, 0);
        chk("rw_udi", udi, 0);
        chk("rw_tx_ready", tx_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rw_cfg", writes, 8'h40);
        cyc(6);
        chk("rw_dropped", tx_n, n0);

        // Randomized traffic vs queue model
        n0 = tx_n;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            tx_valid = 1'($urandom % 2);
            tx_data  = 8'($urandom);
            if (tx_valid && tx_ready) tx_exp.push_back(tx_data);
            rx_ready = ($urandom % 3) != 0;
            if (rx_ready && rx_valid) begin
                exp_b = (rx_exp.size() != 0) ? rx_exp.pop_front() : 8'hxx;
                chk("rnd_rx", rx_data, exp_b);
            end
            tx_rdy_m = ($urandom % 4) != 0;
            if (($urandom % 6) == 0 && (rxm_wr - rxm_rd) < 8) begin
                b = 8'($urandom);
                uart_rx(b);
                rx_exp.push_back(b);
                uart_int = 1'b1;
            end else begin
                uart_int = 1'b0;
            end
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_rdy_m = 1'b1;
        rx_ready = 1'b1;
        k = 0;
        while (k < 400 && ((tx_n - n0) != tx_exp.size()
               || rx_exp.size() != 0 || rxm_wr != rxm_rd)) begin
            if (rx_valid) begin
                exp_b = (rx_exp.size() != 0) ? rx_exp.pop_front() : 8'hxx;
                chk("rnd_rx_drain", rx_data, exp_b);
            end
            uart_int = (k % 4) == 0;
            @(negedge clk);
            k++;
        end
        uart_int = 1'b0;
        rx_ready = 1'b0;
        chk("rnd_tx_count", tx_n - n0, tx_exp.size());
        chk("rnd_rx_left", rx_exp.size(), 0);
        for (int i = 0; i < tx_exp.size(); i++)
            chk("rnd_tx", tx_got[n0 + i], tx_exp[i]);
        chk("rnd_err", err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
